// File: rtl/pc_gen.sv
// pc_gen: registered fetch program counter with stall, exception/ERET
// redirection, decode-stage branch/jump/JR redirects, optional delay-slot
// flushing, misaligned-fetch flag and a saturating redirect counter.
module pc_gen #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
   parameter bit          DELAY_SLOT = 1'b1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [31:0]      epc,
   input  logic             valid_d,
   input  logic [2:0]       op_d,
   input  logic             br_taken_d,
   input  logic [31:0]      pc_d,
   input  logic [25:0]      imm_d,
   input  logic [31:0]      jr_target_d,
   output logic [31:0]      pc_f,
   output logic [31:0]      pc_f_plus4,
   output logic             adel_f,
   output logic             flush_d,
   output logic [31:0]      link_d,
   output logic [CNT_W-1:0] redir_cnt
);

   localparam logic [2:0] OP_BR = 3'd1;
   localparam logic [2:0] OP_J  = 3'd2;
   localparam logic [2:0] OP_JR = 3'd3;

   logic [31:0]      pc_f_q, pc_f_d;
   logic             adel_f_q, adel_f_d;
   logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

   logic [31:0] pc_d_plus4;
   logic [31:0] br_offset;
   logic [31:0] redir_target;
   logic        redir;
   logic        redir_accept;

   // Decode-stage redirect detection and target selection
   always_comb begin
      pc_d_plus4   = pc_d + 32'd4;
      br_offset    = {{14{imm_d[15]}}, imm_d[15:0], 2'b00};
      redir        = 1'b0;
      redir_target = pc_d_plus4;
      case (op_d)
         OP_BR: begin
            redir        = valid_d & br_taken_d;
            redir_target = pc_d_plus4 + br_offset;
         end
         OP_J: begin
            redir        = valid_d;
            redir_target = {pc_d_plus4[31:28], imm_d, 2'b00};
         end
         OP_JR: begin
            redir        = valid_d;
            redir_target = jr_target_d;
         end
         default: begin
            redir        = 1'b0;
            redir_target = pc_d_plus4;
         end
      endcase
      redir_accept = redir & ~stall & ~exc_req & ~eret_req;
   end

   // Next-PC priority: exception, ERET, stall hold, redirect, sequential
   always_comb begin
      pc_f_d      = pc_f_q + 32'd4;
      redir_cnt_d = redir_cnt_q;
      if (exc_req) begin
         pc_f_d = EXC_VECTOR;
      end else if (eret_req) begin
         pc_f_d = epc;
      end else if (stall) begin
         pc_f_d = pc_f_q;
      end else if (redir) begin
         pc_f_d = redir_target;
      end
      adel_f_d = (pc_f_d[1:0] != 2'b00);
      if (redir_accept && (redir_cnt_q != {CNT_W{1'b1}})) begin
         redir_cnt_d = redir_cnt_q + CNT_W'(1);
      end
   end

   // State registers with immediate reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_f_q      <= RESET_PC;
         adel_f_q    <= 1'b0;
         redir_cnt_q <= '0;
      end else begin
         pc_f_q      <= pc_f_d;
         adel_f_q    <= adel_f_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   // Output drive; flush only exists without a delay slot
   always_comb begin
      pc_f       = pc_f_q;
      pc_f_plus4 = pc_f_q + 32'd4;
      adel_f     = adel_f_q;
      redir_cnt  = redir_cnt_q;
      flush_d    = redir_accept & ~DELAY_SLOT;
      link_d     = DELAY_SLOT ? (pc_d + 32'd8) : (pc_d + 32'd4);
   end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances share the inputs, A with a delay slot and
// 16-bit counter, B without delay slot and a 2-bit counter. A spec-level
// model tracks the expected PC, misalignment flag and redirect count.
module tb_pc_gen;

   logic        clk;
   logic        reset;
   logic        stall, exc_req, eret_req, valid_d, br_taken_d;
   logic [31:0] epc, pc_d, jr_target_d;
   logic [2:0]  op_d;
   logic [25:0] imm_d;

   logic [31:0] a_pc_f, a_pc_f_plus4, a_link_d;
   logic        a_adel_f, a_flush_d;
   logic [15:0] a_cnt;
   logic [31:0] b_pc_f, b_pc_f_plus4, b_link_d;
   logic        b_adel_f, b_flush_d;
   logic [1:0]  b_cnt;

   logic [31:0] m_pc;
   logic        m_adel;
   int          m_cnt;
   int          n_checks;
   int          n_fail;

   pc_gen #(.DELAY_SLOT(1'b1), .CNT_W(16)) u_a (
      .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
      .epc(epc), .valid_d(valid_d), .op_d(op_d), .br_taken_d(br_taken_d), .pc_d(pc_d),
      .imm_d(imm_d), .jr_target_d(jr_target_d), .pc_f(a_pc_f), .pc_f_plus4(a_pc_f_plus4),
      .adel_f(a_adel_f), .flush_d(a_flush_d), .link_d(a_link_d), .redir_cnt(a_cnt));

   pc_gen #(.DELAY_SLOT(1'b0), .CNT_W(2)) u_b (
      .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
      .epc(epc), .valid_d(valid_d), .op_d(op_d), .br_taken_d(br_taken_d), .pc_d(pc_d),
      .imm_d(imm_d), .jr_target_d(jr_target_d), .pc_f(b_pc_f), .pc_f_plus4(b_pc_f_plus4),
      .adel_f(b_adel_f), .flush_d(b_flush_d), .link_d(b_link_d), .redir_cnt(b_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Spec rule: a redirect is requested by a valid J, JR or taken BR
   function automatic bit m_redir();
      return valid_d && (op_d == 3'd2 || op_d == 3'd3 || (op_d == 3'd1 && br_taken_d));
   endfunction

   function automatic bit m_accept();
      return m_redir() && !stall && !exc_req && !eret_req;
   endfunction

   function automatic logic [31:0] m_next();
      logic [31:0] p4;
      p4 = pc_d + 32'd4;
      if (exc_req)  return 32'h0000_4180;
      if (eret_req) return epc;
      if (stall)    return m_pc;
      if (m_redir()) begin
         if (op_d == 3'd1) return p4 + 32'($signed(imm_d[15:0])) * 32'd4;
         if (op_d == 3'd2) return (p4 & 32'hF000_0000) | (32'(imm_d) * 32'd4);
         return jr_target_d;
      end
      return m_pc + 32'd4;
   endfunction

   function automatic logic [15:0] m_cnt_a();
      return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
   endfunction

   function automatic logic [1:0] m_cnt_b();
      return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
   endfunction

   task automatic idle();
      stall = 0; exc_req = 0; eret_req = 0; valid_d = 0; br_taken_d = 0;
      op_d = 3'd0; pc_d = 32'h0000_3000; imm_d = '0; jr_target_d = '0; epc = '0;
   endtask

   task automatic apply(input logic [2:0] op, input logic tk, input logic [31:0] pd,
                        input logic [25:0] im, input logic [31:0] jr);
      valid_d = 1; op_d = op; br_taken_d = tk; pc_d = pd; imm_d = im; jr_target_d = jr;
   endtask

   // Advance one clock, updating the model from the inputs seen before the edge
   task automatic tick();
      logic [31:0] nxt;
      bit acc;
      nxt = m_next();
      acc = m_accept();
      @(posedge clk);
      if (reset) begin
         m_pc = 32'h0000_3000; m_adel = 0; m_cnt = 0;
      end else begin
         m_pc = nxt; m_adel = (nxt[1:0] != 2'b00);
         if (acc) m_cnt++;
      end
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      tick();
      #2 reset = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      m_pc = 32'h0000_3000; m_adel = 0; m_cnt = 0;
      #2;
      n_checks++; if (a_pc_f !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", a_pc_f, 32'h0000_3000); end
      n_checks++; if (a_adel_f !== 1'b0) begin n_fail++; $display("FAIL reset_adel: got %b expected 0", a_adel_f); end
      n_checks++; if (a_cnt !== 16'd0 || b_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %h/%h expected 0", a_cnt, b_cnt); end
      tick();
      tick();
      reset = 0;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_seq [3] = '{32'h3004, 32'h3008, 32'h300C};
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (a_pc_f !== exp_seq[i] || b_pc_f !== exp_seq[i]) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h/%h expected %h", i, a_pc_f, b_pc_f, exp_seq[i]); end
      end
      n_checks++; if (a_adel_f !== 1'b0 || a_cnt !== 16'd0) begin n_fail++; $display("FAIL seq_flags: got adel %b cnt %h expected 0 0", a_adel_f, a_cnt); end
   endtask

   task automatic test_branch();
      apply(3'd1, 1'b1, 32'h3004, 26'h000FFFE, 32'h0);
      #2;
      n_checks++; if (a_flush_d !== 1'b0 || a_link_d !== 32'h300C) begin n_fail++; $display("FAIL br_comb_ds1: got flush %b link %h expected 0 300c", a_flush_d, a_link_d); end
      tick();
      n_checks++; if (a_pc_f !== 32'h3000) begin n_fail++; $display("FAIL br_taken_pc: got %h expected 3000", a_pc_f); end
      n_checks++; if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL br_taken_cnt: got %0d expected 1", a_cnt); end
      br_taken_d = 0;
      tick();
      n_checks++; if (a_pc_f !== 32'h3004 || a_cnt !== 16'd1) begin n_fail++; $display("FAIL br_not_taken: got pc %h cnt %0d expected 3004 1", a_pc_f, a_cnt); end
   endtask

   task automatic test_jump();
      apply(3'd2, 1'b0, 32'h3010, 26'h0000C40, 32'h0);
      #2;
      n_checks++; if (b_flush_d !== 1'b1 || b_link_d !== 32'h3014) begin n_fail++; $display("FAIL j_comb_ds0: got flush %b link %h expected 1 3014", b_flush_d, b_link_d); end
      n_checks++; if (a_flush_d !== 1'b0 || a_link_d !== 32'h3018) begin n_fail++; $display("FAIL j_comb_ds1: got flush %b link %h expected 0 3018", a_flush_d, a_link_d); end
      tick();
      n_checks++; if (b_pc_f !== 32'h3100) begin n_fail++; $display("FAIL j_pc: got %h expected 3100", b_pc_f); end
      apply(3'd3, 1'b0, 32'h3100, 26'h0, 32'h3202);
      tick();
      n_checks++; if (b_pc_f !== 32'h3202 || b_adel_f !== 1'b1) begin n_fail++; $display("FAIL jr_pc_adel: got %h %b expected 3202 1", b_pc_f, b_adel_f); end
      n_checks++; if (b_cnt !== 2'd3 || a_cnt !== 16'd3) begin n_fail++; $display("FAIL jr_cnt: got %0d/%0d expected 3/3", b_cnt, a_cnt); end
   endtask

   task automatic test_priority();
      apply(3'd1, 1'b1, 32'h3000, 26'h0000010, 32'h0);
      stall = 1;
      #2;
      n_checks++; if (b_flush_d !== 1'b0) begin n_fail++; $display("FAIL stall_flush: got %b expected 0", b_flush_d); end
      tick();
      n_checks++; if (a_pc_f !== 32'h3202 || a_adel_f !== 1'b1 || a_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_hold: got %h %b %0d expected 3202 1 3", a_pc_f, a_adel_f, a_cnt); end
      exc_req = 1;
      #2;
      n_checks++; if (b_flush_d !== 1'b0) begin n_fail++; $display("FAIL exc_flush: got %b expected 0", b_flush_d); end
      tick();
      n_checks++; if (a_pc_f !== 32'h4180 || a_adel_f !== 1'b0 || a_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_exc: got %h %b %0d expected 4180 0 3", a_pc_f, a_adel_f, a_cnt); end
      stall = 0; valid_d = 0; eret_req = 1; epc = 32'h3008;
      tick();
      n_checks++; if (a_pc_f !== 32'h4180) begin n_fail++; $display("FAIL exc_over_eret: got %h expected 4180", a_pc_f); end
      exc_req = 0;
      tick();
      n_checks++; if (a_pc_f !== 32'h3008 || b_pc_f !== 32'h3008) begin n_fail++; $display("FAIL eret: got %h/%h expected 3008", a_pc_f, b_pc_f); end
      idle();
   endtask

   task automatic test_saturation();
      logic [1:0] exp_b [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply(3'd2, 1'b0, 32'h3000, 26'h0000C00 + 26'(i), 32'h0);
         tick();
         n_checks++; if (b_cnt !== exp_b[i] || a_cnt !== 16'(i + 1)) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, b_cnt, a_cnt, exp_b[i], i + 1); end
      end
      idle();
   endtask

   task automatic test_wrap();
      apply(3'd2, 1'b0, 32'hF000_0000, 26'h3FF_FFFF, 32'h0);
      tick();
      n_checks++; if (a_pc_f !== 32'hFFFF_FFFC || a_pc_f_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_j: got %h plus4 %h expected fffffffc 0", a_pc_f, a_pc_f_plus4); end
      idle();
      tick();
      n_checks++; if (a_pc_f !== 32'h0 || a_adel_f !== 1'b0) begin n_fail++; $display("FAIL wrap_seq: got %h %b expected 0 0", a_pc_f, a_adel_f); end
   endtask

   task automatic test_async_reset();
      apply(3'd3, 1'b0, 32'h0, 26'h0, 32'h5000);
      tick();
      apply(3'd2, 1'b0, 32'h5000, 26'h0001000, 32'h0);
      #1 reset = 1;
      m_pc = 32'h0000_3000; m_adel = 0; m_cnt = 0;
      #1;
      n_checks++; if (a_pc_f !== 32'h3000 || b_pc_f !== 32'h3000) begin n_fail++; $display("FAIL async_pc: got %h/%h expected 3000", a_pc_f, b_pc_f); end
      n_checks++; if (a_cnt !== 16'd0 || b_cnt !== 2'd0) begin n_fail++; $display("FAIL async_cnt: got %0d/%0d expected 0", a_cnt, b_cnt); end
      tick();
      reset = 0;
      idle();
      tick();
      n_checks++; if (a_pc_f !== 32'h3004) begin n_fail++; $display("FAIL async_release: got %h expected 3004", a_pc_f); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         stall = ($urandom_range(3) == 0);
         exc_req = ($urandom_range(15) == 0);
         eret_req = ($urandom_range(15) == 0);
         epc = $urandom & ~32'($urandom_range(1) * 3);
         valid_d = ($urandom_range(3) != 0);
         op_d = 3'($urandom_range(7));
         br_taken_d = 1'($urandom);
         pc_d = $urandom & 32'hFFFF_FFFC;
         imm_d = 26'($urandom);
         jr_target_d = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         #2;
         n_checks++; if (a_flush_d !== 1'b0 || b_flush_d !== 1'(m_accept())) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b/%b expected 0/%b", i, a_flush_d, b_flush_d, m_accept()); end
         n_checks++; if (a_link_d !== pc_d + 32'd8 || b_link_d !== pc_d + 32'd4) begin n_fail++; $display("FAIL rnd_link[%0d]: got %h/%h pc_d %h", i, a_link_d, b_link_d, pc_d); end
         n_checks++; if (a_pc_f_plus4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_plus4[%0d]: got %h expected %h", i, a_pc_f_plus4, m_pc + 32'd4); end
         tick();
         n_checks++; if (a_pc_f !== m_pc || b_pc_f !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h/%h expected %h", i, a_pc_f, b_pc_f, m_pc); end
         n_checks++; if (a_adel_f !== m_adel || b_adel_f !== m_adel) begin n_fail++; $display("FAIL rnd_adel[%0d]: got %b/%b expected %b", i, a_adel_f, b_adel_f, m_adel); end
         n_checks++; if (a_cnt !== m_cnt_a() || b_cnt !== m_cnt_b()) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, a_cnt, b_cnt, m_cnt_a(), m_cnt_b()); end
      end
      idle();
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_priority();
      test_saturation();
      test_wrap();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
